// File: rtl/adder_share_arb.sv
// Two requesters time-share one adder/comparator behind a round-robin arbiter.
// Latency: accept in cycle c, response valid in cycle c+2. Throughput is one op per cycle.
// Backpressure: a full, unpopped result slot stalls the issue register and drops both request readies.

// Combinational add/subtract with carry, signed overflow and a one-hot compare select.
module logic_adder #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            sub_i,
    input  logic [5:0]      sel_i,
    output logic [XLEN-1:0] sum_o,
    output logic            flag_o,
    output logic            cout_o,
    output logic            ovf_o
);
    logic [XLEN-1:0] b_x;
    logic [XLEN:0]   full;
    logic            eq;
    logic            ltu;
    logic            lt;

    assign b_x    = b_i ^ {XLEN{sub_i}};
    assign full   = {1'b0, a_i} + {1'b0, b_x} + {{XLEN{1'b0}}, sub_i};
    assign sum_o  = full[XLEN-1:0];
    assign cout_o = full[XLEN];
    assign ovf_o  = (a_i[XLEN-1] == b_x[XLEN-1]) & (sum_o[XLEN-1] != a_i[XLEN-1]);

    // Compare results are read off the subtraction: zero sum, borrow, sign xor overflow.
    assign eq  = (sum_o == '0);
    assign ltu = ~cout_o;
    assign lt  = sum_o[XLEN-1] ^ ovf_o;

    // Select one compare result; unknown encodings give 0.
    always_comb begin
        flag_o = 1'b0;
        case (sel_i)
            6'b000001: flag_o = eq;
            6'b000010: flag_o = ~eq;
            6'b000100: flag_o = ltu;
            6'b001000: flag_o = ~ltu;
            6'b010000: flag_o = lt;
            6'b100000: flag_o = ~lt;
            default:   flag_o = 1'b0;
        endcase
    end
endmodule

module adder_share_arb #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            rq0_valid_i,
    output logic            rq0_ready_o,
    input  logic [XLEN-1:0] rq0_a_i,
    input  logic [XLEN-1:0] rq0_b_i,
    input  logic            rq0_sub_i,
    input  logic [5:0]      rq0_sel_i,
    input  logic            rq1_valid_i,
    output logic            rq1_ready_o,
    input  logic [XLEN-1:0] rq1_a_i,
    input  logic [XLEN-1:0] rq1_b_i,
    input  logic            rq1_sub_i,
    input  logic [5:0]      rq1_sel_i,
    output logic            rs0_valid_o,
    input  logic            rs0_ready_i,
    output logic [XLEN-1:0] rs0_sum_o,
    output logic            rs0_flag_o,
    output logic            rs0_cout_o,
    output logic            rs0_ovf_o,
    output logic            rs1_valid_o,
    input  logic            rs1_ready_i,
    output logic [XLEN-1:0] rs1_sum_o,
    output logic            rs1_flag_o,
    output logic            rs1_cout_o,
    output logic            rs1_ovf_o
);
    logic            run_q;
    logic            ptr_q, ptr_d;
    logic            s1_vld_q, s1_vld_d;
    logic            s1_id_q;
    logic [XLEN-1:0] s1_a_q, s1_b_q;
    logic            s1_sub_q;
    logic [5:0]      s1_sel_q;
    logic [1:0]      slot_vld_q, slot_vld_d;
    logic [XLEN-1:0] slot_sum_q [2];
    logic [1:0]      slot_flag_q, slot_cout_q, slot_ovf_q;

    logic [XLEN-1:0] add_sum;
    logic            add_flag, add_cout, add_ovf;
    logic [1:0]      rq_vld, pop, grant, rq_rdy;
    logic            retire, s1_free, accept, acc_id;

    assign rq_vld = {rq1_valid_i, rq0_valid_i};
    assign pop    = slot_vld_q & {rs1_ready_i, rs0_ready_i};

    // The only adder; its inputs come straight from the issue register.
    logic_adder #(.XLEN(XLEN)) u_adder (
        .a_i    (s1_a_q),
        .b_i    (s1_b_q),
        .sub_i  (s1_sub_q),
        .sel_i  (s1_sel_q),
        .sum_o  (add_sum),
        .flag_o (add_flag),
        .cout_o (add_cout),
        .ovf_o  (add_ovf)
    );

    // Retire/arbitrate/accept decisions and next-state for the valid bits and pointer.
    always_comb begin
        retire     = s1_vld_q & (~slot_vld_q[s1_id_q] | pop[s1_id_q]);
        s1_free    = ~s1_vld_q | retire;
        grant[0]   = rq_vld[0] & (~ptr_q | ~rq_vld[1]);
        grant[1]   = rq_vld[1] & (ptr_q | ~rq_vld[0]);
        // run_q keeps readies low during reset and on the first edge after release.
        rq_rdy     = grant & {2{s1_free & run_q & ~flush_i}};
        accept     = |rq_rdy;
        acc_id     = rq_rdy[1];
        ptr_d      = ptr_q;
        s1_vld_d   = s1_vld_q;
        slot_vld_d = slot_vld_q & ~pop;
        if (retire) begin
            slot_vld_d[s1_id_q] = 1'b1;
            s1_vld_d            = 1'b0;
        end
        if (accept) begin
            s1_vld_d = 1'b1;
            ptr_d    = ~acc_id;
        end
        if (flush_i) begin
            s1_vld_d   = 1'b0;
            slot_vld_d = 2'b00;
            ptr_d      = 1'b0;
        end
    end

    // Control state: valids, round-robin pointer and the out-of-reset marker.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q      <= 1'b0;
            ptr_q      <= 1'b0;
            s1_vld_q   <= 1'b0;
            slot_vld_q <= 2'b00;
        end else begin
            run_q      <= 1'b1;
            ptr_q      <= ptr_d;
            s1_vld_q   <= s1_vld_d;
            slot_vld_q <= slot_vld_d;
        end
    end

    // Issue register loads only on accept, so adder inputs stay put otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_id_q  <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_sub_q <= 1'b0;
            s1_sel_q <= '0;
        end else if (accept) begin
            s1_id_q  <= acc_id;
            s1_a_q   <= acc_id ? rq1_a_i   : rq0_a_i;
            s1_b_q   <= acc_id ? rq1_b_i   : rq0_b_i;
            s1_sub_q <= acc_id ? rq1_sub_i : rq0_sub_i;
            s1_sel_q <= acc_id ? rq1_sel_i : rq0_sel_i;
        end
    end

    // Result slots capture adder outputs when the issue register retires into them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_sum_q[0] <= '0;
            slot_sum_q[1] <= '0;
            slot_flag_q   <= 2'b00;
            slot_cout_q   <= 2'b00;
            slot_ovf_q    <= 2'b00;
        end else if (retire && !flush_i) begin
            slot_sum_q[s1_id_q]  <= add_sum;
            slot_flag_q[s1_id_q] <= add_flag;
            slot_cout_q[s1_id_q] <= add_cout;
            slot_ovf_q[s1_id_q]  <= add_ovf;
        end
    end

    assign rq0_ready_o = rq_rdy[0];
    assign rq1_ready_o = rq_rdy[1];
    assign rs0_valid_o = slot_vld_q[0];
    assign rs0_sum_o   = slot_sum_q[0];
    assign rs0_flag_o  = slot_flag_q[0];
    assign rs0_cout_o  = slot_cout_q[0];
    assign rs0_ovf_o   = slot_ovf_q[0];
    assign rs1_valid_o = slot_vld_q[1];
    assign rs1_sum_o   = slot_sum_q[1];
    assign rs1_flag_o  = slot_flag_q[1];
    assign rs1_cout_o  = slot_cout_q[1];
    assign rs1_ovf_o   = slot_ovf_q[1];
endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: vector table driven through per-requester stimulus queues,
// responses checked against a per-requester scoreboard, plus hand-built stall/flush/reset sequences.
module tb_adder_share_arb;
    typedef struct {
        int          k;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [5:0]  sel;
        logic [31:0] sum;
        logic        flag;
        logic        cout;
        logic        ovf;
        logic        chk_flag;
    } vec_t;

    typedef struct {
        vec_t v;
        int   cyc;
    } exp_t;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             flush_i = 1'b0;
    logic [1:0]       rq_vld = 2'b00;
    logic [1:0]       rq_rdy;
    logic [1:0][31:0] rq_a = '0;
    logic [1:0][31:0] rq_b = '0;
    logic [1:0]       rq_sub = 2'b00;
    logic [1:0][5:0]  rq_sel = '0;
    logic [1:0]       rs_vld;
    logic [1:0]       rs_rdy = 2'b11;
    logic [1:0][31:0] rs_sum;
    logic [1:0]       rs_flag, rs_cout, rs_ovf;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    bit    lat_chk = 1'b1;
    vec_t  vecs [12];
    vec_t  cur [2];
    vec_t  stim0 [$];
    vec_t  stim1 [$];
    exp_t  sb0 [$];
    exp_t  sb1 [$];
    int    acc_log [$];
    int    rsp0_cyc [$];
    logic [1:0] acc_seen = 2'b00;
    logic [1:0] hold = 2'b00;
    logic [1:0][31:0] hold_sum;
    exp_t  mon_e;
    bit    mon_have;

    adder_share_arb #(.XLEN(32)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .rq0_valid_i (rq_vld[0]),
        .rq0_ready_o (rq_rdy[0]),
        .rq0_a_i     (rq_a[0]),
        .rq0_b_i     (rq_b[0]),
        .rq0_sub_i   (rq_sub[0]),
        .rq0_sel_i   (rq_sel[0]),
        .rq1_valid_i (rq_vld[1]),
        .rq1_ready_o (rq_rdy[1]),
        .rq1_a_i     (rq_a[1]),
        .rq1_b_i     (rq_b[1]),
        .rq1_sub_i   (rq_sub[1]),
        .rq1_sel_i   (rq_sel[1]),
        .rs0_valid_o (rs_vld[0]),
        .rs0_ready_i (rs_rdy[0]),
        .rs0_sum_o   (rs_sum[0]),
        .rs0_flag_o  (rs_flag[0]),
        .rs0_cout_o  (rs_cout[0]),
        .rs0_ovf_o   (rs_ovf[0]),
        .rs1_valid_o (rs_vld[1]),
        .rs1_ready_i (rs_rdy[1]),
        .rs1_sum_o   (rs_sum[1]),
        .rs1_flag_o  (rs_flag[1]),
        .rs1_cout_o  (rs_cout[1]),
        .rs1_ovf_o   (rs_ovf[1])
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic apply(input int k, input vec_t v);
        cur[k]    = v;
        rq_vld[k] = 1'b1;
        rq_a[k]   = v.a;
        rq_b[k]   = v.b;
        rq_sub[k] = v.sub;
        rq_sel[k] = v.sel;
    endtask

    task automatic push_vec(input int i);
        if (vecs[i].k == 0) stim0.push_back(vecs[i]);
        else                stim1.push_back(vecs[i]);
    endtask

    // Requester drivers: hold each request until the handshake, then present the next one.
    always @(posedge clk_i) begin
        #1;
        if (rq_vld[0] && acc_seen[0]) rq_vld[0] = 1'b0;
        if (rq_vld[1] && acc_seen[1]) rq_vld[1] = 1'b0;
        acc_seen = 2'b00;
        if (!rq_vld[0] && stim0.size() > 0) apply(0, stim0.pop_front());
        if (!rq_vld[1] && stim1.size() > 0) apply(1, stim1.pop_front());
    end

    // Monitor: push expectations on accept, pop and compare on response, check hold stability.
    always @(negedge clk_i) begin
        for (int k = 0; k < 2; k++) begin
            if (hold[k] && rst_ni) begin
                chk($sformatf("rs%0d_hold_vld", k), {31'b0, rs_vld[k]}, 32'd1);
                chk($sformatf("rs%0d_hold_sum", k), rs_sum[k], hold_sum[k]);
            end
            hold[k]     = rs_vld[k] && !rs_rdy[k] && !flush_i && rst_ni;
            hold_sum[k] = rs_sum[k];
            if (rq_vld[k] && rq_rdy[k]) begin
                acc_seen[k] = 1'b1;
                acc_log.push_back(k);
                mon_e.v   = cur[k];
                mon_e.cyc = cyc;
                if (k == 0) sb0.push_back(mon_e);
                else        sb1.push_back(mon_e);
            end
            if (rs_vld[k] && rs_rdy[k]) begin
                mon_have = (k == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
                chk($sformatf("rs%0d_expected", k), {31'b0, mon_have}, 32'd1);
                if (mon_have) begin
                    mon_e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
                    if (k == 0) rsp0_cyc.push_back(cyc);
                    chk($sformatf("rs%0d_sum", k), rs_sum[k], mon_e.v.sum);
                    chk($sformatf("rs%0d_cout", k), {31'b0, rs_cout[k]}, {31'b0, mon_e.v.cout});
                    chk($sformatf("rs%0d_ovf", k), {31'b0, rs_ovf[k]}, {31'b0, mon_e.v.ovf});
                    if (mon_e.v.chk_flag)
                        chk($sformatf("rs%0d_flag", k), {31'b0, rs_flag[k]}, {31'b0, mon_e.v.flag});
                    if (lat_chk)
                        chk($sformatf("rs%0d_latency", k), cyc - mon_e.cyc, 32'd2);
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((stim0.size() != 0 || stim1.size() != 0 || rq_vld != 2'b00 ||
                sb0.size() != 0 || sb1.size() != 0) && n < budget) begin
            @(posedge clk_i);
            #2;
            n++;
        end
        chk("drain_timeout", {31'b0, (n >= budget)}, 32'd0);
    endtask

    task automatic clear_tb();
        rq_vld   = 2'b00;
        acc_seen = 2'b00;
        stim0.delete();
        stim1.delete();
        sb0.delete();
        sb1.delete();
        acc_log.delete();
        rsp0_cyc.delete();
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        clear_tb();
        @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
    endtask

    task automatic first_acc_is_rq0(input string nm);
        chk(nm, (acc_log.size() > 0) ? acc_log[0] : 99, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0, 32'd5,          32'd7,          1'b0, 6'b000000, 32'd12,         1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1, 32'd3,          32'd5,          1'b1, 6'b000100, 32'hFFFFFFFE,   1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{0, 32'h80000000,   32'd1,          1'b1, 6'b010000, 32'h7FFFFFFF,   1'b1, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{1, 32'hFFFFFFFF,   32'd1,          1'b0, 6'b000000, 32'h00000000,   1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{0, 32'h7FFFFFFF,   32'd1,          1'b0, 6'b000000, 32'h80000000,   1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1, 32'd10,         32'd10,         1'b1, 6'b000001, 32'h00000000,   1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{0, 32'd10,         32'd10,         1'b1, 6'b000010, 32'h00000000,   1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1, 32'd5,          32'd3,          1'b1, 6'b001000, 32'd2,          1'b1, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{0, 32'hFFFFFFFF,   32'd1,          1'b1, 6'b100000, 32'hFFFFFFFE,   1'b0, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1, 32'hFFFFFFFF,   32'd1,          1'b1, 6'b001000, 32'hFFFFFFFE,   1'b1, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{0, 32'd1,          32'hFFFFFFFF,   1'b1, 6'b010000, 32'd2,          1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1, 32'd3,          32'd5,          1'b1, 6'b000011, 32'hFFFFFFFE,   1'b0, 1'b0, 1'b0, 1'b1};

        // Reset state with both requesters already asserting valid.
        push_vec(0);
        push_vec(1);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_rq0_ready", {31'b0, rq_rdy[0]}, 32'd0);
        chk("reset_rq1_ready", {31'b0, rq_rdy[1]}, 32'd0);
        chk("reset_rs0_valid", {31'b0, rs_vld[0]}, 32'd0);
        chk("reset_rs1_valid", {31'b0, rs_vld[1]}, 32'd0);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        wait_idle(50);
        first_acc_is_rq0("first_accept_after_reset");

        // Vector table, one op at a time.
        for (int i = 0; i < 12; i++) begin
            push_vec(i);
            wait_idle(50);
        end

        // Both requesters valid every cycle from reset: accepts alternate, latency 2.
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        clear_tb();
        for (int i = 0; i < 8; i++) push_vec(i);
        repeat (2) @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        wait_idle(80);
        chk("alt_count", acc_log.size(), 32'd8);
        for (int i = 0; i < acc_log.size(); i++)
            chk($sformatf("alt_order_%0d", i), acc_log[i], i % 2);

        // Head-of-line blocking on a full slot, then drain one per cycle.
        do_reset();
        lat_chk   = 1'b0;
        rs_rdy[0] = 1'b0;
        push_vec(0);
        push_vec(2);
        push_vec(4);
        repeat (6) @(posedge clk_i);
        @(negedge clk_i);
        chk("hol_rs0_valid", {31'b0, rs_vld[0]}, 32'd1);
        chk("hol_rs0_sum", rs_sum[0], 32'd12);
        chk("hol_rq0_ready", {31'b0, rq_rdy[0]}, 32'd0);
        chk("hol_rq1_ready", {31'b0, rq_rdy[1]}, 32'd0);
        @(posedge clk_i);
        #2;
        rs_rdy[0] = 1'b1;
        wait_idle(50);
        chk("hol_rsp_count", rsp0_cyc.size(), 32'd3);
        if (rsp0_cyc.size() == 3) begin
            chk("hol_gap_1", rsp0_cyc[1] - rsp0_cyc[0], 32'd1);
            chk("hol_gap_2", rsp0_cyc[2] - rsp0_cyc[1], 32'd1);
        end

        // Flush with S1 and both slots occupied.
        do_reset();
        rs_rdy = 2'b00;
        push_vec(0);
        push_vec(2);
        push_vec(1);
        repeat (6) @(posedge clk_i);
        @(negedge clk_i);
        chk("pre_flush_rs0_valid", {31'b0, rs_vld[0]}, 32'd1);
        chk("pre_flush_rs1_valid", {31'b0, rs_vld[1]}, 32'd1);
        @(posedge clk_i);
        #2;
        flush_i = 1'b1;
        @(posedge clk_i);
        #2;
        flush_i = 1'b0;
        @(negedge clk_i);
        chk("flush_rs0_valid", {31'b0, rs_vld[0]}, 32'd0);
        chk("flush_rs1_valid", {31'b0, rs_vld[1]}, 32'd0);
        sb0.delete();
        sb1.delete();
        acc_log.delete();
        rs_rdy = 2'b11;
        repeat (4) @(posedge clk_i);
        #2;
        push_vec(0);
        push_vec(1);
        wait_idle(50);
        first_acc_is_rq0("flush_ptr_reset");

        // Asynchronous reset with S1 and both slots occupied.
        do_reset();
        rs_rdy = 2'b00;
        push_vec(0);
        push_vec(2);
        push_vec(1);
        repeat (6) @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_rs0_valid", {31'b0, rs_vld[0]}, 32'd0);
        chk("arst_rs1_valid", {31'b0, rs_vld[1]}, 32'd0);
        chk("arst_rq0_ready", {31'b0, rq_rdy[0]}, 32'd0);
        clear_tb();
        @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        rs_rdy = 2'b11;
        repeat (4) @(posedge clk_i);
        #2;
        push_vec(0);
        push_vec(1);
        wait_idle(50);
        first_acc_is_rq0("arst_ptr_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
